// File: rtl/fe_invert.sv
// fe_invert: inverse in GF(2^255-19) as a^(p-2), one square-and-multiply step per femul operation.
// femul is a one-cycle modular multiplier with start/done. It has no reset, so fe_invert flushes after reset.
module femul (
    input  logic         clk,
    input  logic         start,
    input  logic [254:0] a,
    input  logic [254:0] b,
    output logic         done,
    output logic [254:0] out
);
    localparam logic [255:0] P = (256'd1 << 255) - 256'd19;
    logic [509:0] prod;
    logic [259:0] t;
    logic [255:0] u;
    logic         done_d, done_q;
    logic [254:0] out_d, out_q;
    // 2^255 == 19 mod p; two folds leave u < 2p, so one conditional subtract is canonical.
    always_comb begin
        prod   = 510'(a) * 510'(b);
        t      = 260'(prod[254:0]) + 260'(prod[509:255]) * 260'd19;
        u      = 256'(t[254:0]) + 256'(t[259:255]) * 256'd19;
        out_d  = u >= P ? 255'(u - P) : u[254:0];
        done_d = start;
    end
    always_ff @(posedge clk) begin
        done_q <= done_d;
        out_q  <= out_d;
    end
    assign done = done_q;
    assign out  = out_q;
endmodule

module fe_invert #(
    parameter int FLUSH_CYCLES = 40,
    parameter int IDX_W        = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [254:0] a_in,
    output logic         busy,
    output logic         done,
    output logic [254:0] out
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    typedef enum logic [2:0] {FLUSH, IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, FINISH} state_t;
    state_t       state_d, state_q;
    logic [FW-1:0]    flush_d, flush_q;
    logic [IDX_W-1:0] idx_d, idx_q;
    logic [254:0] a_d, a_q, r_d, r_q, out_d, out_q;
    logic         busy_d, busy_q, done_d, done_q, mul_start_d, mul_start_q;
    logic         mul_done, e_bit;
    logic [254:0] mul_b, mul_out;
    // p-2 = 2^255-21: every exponent bit below 255 is set except bits 4 and 2.
    assign e_bit = !(idx_q == IDX_W'(4) || idx_q == IDX_W'(2));
    assign mul_b = (state_q == MUL_ISSUE || state_q == MUL_WAIT) ? a_q : r_q;
    femul u_mul (
        .clk   (clock),
        .start (mul_start_q),
        .a     (r_q),
        .b     (mul_b),
        .done  (mul_done),
        .out   (mul_out)
    );
    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        idx_d   = idx_q;
        a_d     = a_q;
        r_d     = r_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            FLUSH: begin
                flush_d = flush_q + 1'b1;
                if (flush_q == FW'(FLUSH_CYCLES - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            IDLE: if (start) begin
                a_d     = a_in;
                r_d     = a_in;
                idx_d   = IDX_W'(253);
                busy_d  = 1'b1;
                state_d = SQ_ISSUE;
            end
            SQ_ISSUE: state_d = SQ_WAIT;
            SQ_WAIT: if (mul_done) begin
                r_d     = mul_out;
                state_d = e_bit ? MUL_ISSUE : NEXT;
            end
            MUL_ISSUE: state_d = MUL_WAIT;
            MUL_WAIT: if (mul_done) begin
                r_d     = mul_out;
                state_d = NEXT;
            end
            NEXT: if (idx_q == '0) begin
                state_d = FINISH;
                out_d   = r_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                idx_d   = idx_q - 1'b1;
                state_d = SQ_ISSUE;
            end
            FINISH: state_d = IDLE;
            default: state_d = FLUSH;
        endcase
        mul_start_d = state_d == SQ_ISSUE || state_d == MUL_ISSUE;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= FLUSH;
            flush_q     <= '0;
            idx_q       <= '0;
            a_q         <= '0;
            r_q         <= '0;
            out_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            r_q         <= r_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mul_start_q <= mul_start_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
endmodule
